// File: rtl/dxy_corner_fetch.sv
// Dxy corner fetcher: turns one (x, y, s) Hessian request into 16 sequential
// integral-image reads and presents the corners A..P with a single valid pulse.
module dxy_corner_fetch #(
  parameter int DATA_WIDTH = 28,
  parameter int ADDR_W     = 16,
  parameter int COORD_W    = 10,
  parameter int S_W        = 6,
  parameter int IMG_W      = 64,
  parameter int IMG_H      = 64,
  parameter int RD_LAT     = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [COORD_W-1:0]    req_x,
  input  logic [COORD_W-1:0]    req_y,
  input  logic [S_W-1:0]        req_s,
  output logic                  rd_en,
  output logic [ADDR_W-1:0]     rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic [DATA_WIDTH-1:0] A, B, C, D, E, F, G, H,
  output logic [DATA_WIDTH-1:0] I, J, K, L, M, N, O, P,
  output logic                  dout_valid,
  output logic                  err
);

  localparam int CW = ((COORD_W > S_W) ? COORD_W : S_W) + 2;
  localparam logic [CW-1:0]     ONE        = CW'(1);
  localparam logic [CW-1:0]     X_MAX      = CW'(IMG_W - 1);
  localparam logic [CW-1:0]     Y_MAX      = CW'(IMG_H - 1);
  localparam logic [ADDR_W-1:0] ROW_STRIDE = ADDR_W'(IMG_W);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DRAIN = 2'd2} state_t;

  state_t                  state_q;
  logic [ADDR_W-1:0]       row_base_q [4];
  logic [ADDR_W-1:0]       col_q      [4];
  logic [ADDR_W-1:0]       row_base_d [4];
  logic [ADDR_W-1:0]       col_d      [4];
  logic [CW-1:0]           row_s      [4];
  logic [CW-1:0]           col_s      [4];
  logic [CW-1:0]           x_s, y_s, s_s;
  logic [4:0]              issue_cnt_q;
  logic [3:0]              cap_cnt_q;
  logic [RD_LAT-1:0]       vld_pipe_q;
  logic                    rd_en_q, dout_valid_q, err_q;
  logic                    accept_s, reject_s;
  logic [ADDR_W-1:0]       rd_addr_q, issue_addr_s;
  logic [DATA_WIDTH-1:0]   corner_q [16];

  // Request decode: bounds check and the four row bases / columns of the corner grid.
  always_comb begin
    x_s      = CW'(req_x);
    y_s      = CW'(req_y);
    s_s      = CW'(req_s);
    accept_s = req_valid && (state_q == IDLE);
    reject_s = (s_s == '0) || (x_s < s_s + ONE) || (y_s < s_s + ONE) ||
               (x_s + s_s > X_MAX) || (y_s + s_s > Y_MAX);
    row_s[0] = y_s - s_s - ONE;
    row_s[1] = y_s - ONE;
    row_s[2] = y_s;
    row_s[3] = y_s + s_s;
    col_s[0] = x_s - s_s - ONE;
    col_s[1] = x_s - ONE;
    col_s[2] = x_s;
    col_s[3] = x_s + s_s;
    for (int i = 0; i < 4; i++) begin
      row_base_d[i] = ADDR_W'(row_s[i]) * ROW_STRIDE;
      col_d[i]      = ADDR_W'(col_s[i]);
    end
  end

  // Index k walks A..P: bits {k[1],k[2]} pick the row, bits {k[3],k[0]} pick the column.
  always_comb begin
    issue_addr_s = row_base_q[{issue_cnt_q[1], issue_cnt_q[2]}] +
                   col_q[{issue_cnt_q[3], issue_cnt_q[0]}];
  end

  // Control FSM, read issue, capture pipeline and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rd_en_q      <= 1'b0;
      rd_addr_q    <= '0;
      dout_valid_q <= 1'b0;
      err_q        <= 1'b0;
      issue_cnt_q  <= 5'd0;
      cap_cnt_q    <= 4'd0;
      vld_pipe_q   <= '0;
      for (int i = 0; i < 4; i++) begin
        row_base_q[i] <= '0;
        col_q[i]      <= '0;
      end
      for (int i = 0; i < 16; i++) begin
        corner_q[i] <= '0;
      end
    end else begin
      err_q        <= 1'b0;
      dout_valid_q <= 1'b0;
      vld_pipe_q   <= RD_LAT'({vld_pipe_q, rd_en_q});
      if (vld_pipe_q[RD_LAT-1]) begin
        corner_q[cap_cnt_q] <= rd_data;
        cap_cnt_q           <= cap_cnt_q + 4'd1;
      end
      case (state_q)
        IDLE: begin
          if (accept_s && reject_s) begin
            err_q <= 1'b1;
          end else if (accept_s) begin
            state_q     <= ISSUE;
            rd_en_q     <= 1'b1;
            rd_addr_q   <= row_base_d[0] + col_d[0];
            row_base_q  <= row_base_d;
            col_q       <= col_d;
            issue_cnt_q <= 5'd1;
          end
        end
        ISSUE: begin
          if (issue_cnt_q == 5'd16) begin
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            state_q   <= DRAIN;
          end else begin
            rd_addr_q   <= issue_addr_s;
            issue_cnt_q <= issue_cnt_q + 5'd1;
          end
        end
        DRAIN: begin
          if (vld_pipe_q[RD_LAT-1] && (cap_cnt_q == 4'd15)) begin
            dout_valid_q <= 1'b1;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign rd_en      = rd_en_q;
  assign rd_addr    = rd_addr_q;
  assign dout_valid = dout_valid_q;
  assign err        = err_q;
  assign A = corner_q[0];   assign B = corner_q[1];
  assign C = corner_q[2];   assign D = corner_q[3];
  assign E = corner_q[4];   assign F = corner_q[5];
  assign G = corner_q[6];   assign H = corner_q[7];
  assign I = corner_q[8];   assign J = corner_q[9];
  assign K = corner_q[10];  assign L = corner_q[11];
  assign M = corner_q[12];  assign N = corner_q[13];
  assign O = corner_q[14];  assign P = corner_q[15];

endmodule

// File: tb/tb_dxy_corner_fetch.sv
// Bench for dxy_corner_fetch: two builds (RD_LAT=1 and RD_LAT=3) against a
// coordinate-level corner model and direct box sums over the source image.
module tb_dxy_corner_fetch;
  localparam int DW = 28, AW = 16, CW = 10, SW = 6, IW = 64, IH = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, rv1, rv3, rr1, rr3, re1, re3, dv1, dv3, er1, er3;
  logic [CW-1:0] rx, ry;
  logic [SW-1:0] rs;
  logic [AW-1:0] ra1, ra3;
  logic [DW-1:0] rd1, rd3, p3a, p3b;
  logic [DW-1:0] c1 [16];
  logic [DW-1:0] c3 [16];
  logic [DW-1:0] mem [IW*IH];
  logic [DW-1:0] prev [2][16];
  int            img [IH][IW];
  int            n_cmp = 0, n_bad = 0;

  dxy_corner_fetch #(.DATA_WIDTH(DW), .ADDR_W(AW), .COORD_W(CW), .S_W(SW),
                     .IMG_W(IW), .IMG_H(IH), .RD_LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(rv1), .req_ready(rr1),
    .req_x(rx), .req_y(ry), .req_s(rs), .rd_en(re1), .rd_addr(ra1), .rd_data(rd1),
    .A(c1[0]), .B(c1[1]), .C(c1[2]), .D(c1[3]), .E(c1[4]), .F(c1[5]), .G(c1[6]), .H(c1[7]),
    .I(c1[8]), .J(c1[9]), .K(c1[10]), .L(c1[11]), .M(c1[12]), .N(c1[13]), .O(c1[14]), .P(c1[15]),
    .dout_valid(dv1), .err(er1));

  dxy_corner_fetch #(.DATA_WIDTH(DW), .ADDR_W(AW), .COORD_W(CW), .S_W(SW),
                     .IMG_W(IW), .IMG_H(IH), .RD_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(rv3), .req_ready(rr3),
    .req_x(rx), .req_y(ry), .req_s(rs), .rd_en(re3), .rd_addr(ra3), .rd_data(rd3),
    .A(c3[0]), .B(c3[1]), .C(c3[2]), .D(c3[3]), .E(c3[4]), .F(c3[5]), .G(c3[6]), .H(c3[7]),
    .I(c3[8]), .J(c3[9]), .K(c3[10]), .L(c3[11]), .M(c3[12]), .N(c3[13]), .O(c3[14]), .P(c3[15]),
    .dout_valid(dv3), .err(er3));

  // Integral-image RAMs with one and three cycles of read latency.
  always @(posedge clk) begin
    rd1 <= mem[ra1[11:0]];
    p3a <= mem[ra3[11:0]];
    p3b <= p3a;
    rd3 <= p3b;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic o_en(int sel);  return (sel == 3) ? re3 : re1; endfunction
  function automatic logic o_dv(int sel);  return (sel == 3) ? dv3 : dv1; endfunction
  function automatic logic o_err(int sel); return (sel == 3) ? er3 : er1; endfunction
  function automatic logic o_rdy(int sel); return (sel == 3) ? rr3 : rr1; endfunction
  function automatic logic [AW-1:0] o_addr(int sel); return (sel == 3) ? ra3 : ra1; endfunction
  function automatic logic [DW-1:0] o_c(int sel, int i); return (sel == 3) ? c3[i] : c1[i]; endfunction

  task automatic set_rv(input int sel, input logic v);
    if (sel == 3) rv3 = v; else rv1 = v;
  endtask

  // Corner letter k (A=0 .. P=15) as (row, col) in the image, flattened to an address.
  function automatic int corner_addr(int k, int x, int y, int s);
    int r, c;
    case (k)
      0:  begin r = y - s - 1; c = x - s - 1; end
      1:  begin r = y - s - 1; c = x - 1;     end
      2:  begin r = y;         c = x - s - 1; end
      3:  begin r = y;         c = x - 1;     end
      4:  begin r = y - 1;     c = x - s - 1; end
      5:  begin r = y - 1;     c = x - 1;     end
      6:  begin r = y + s;     c = x - s - 1; end
      7:  begin r = y + s;     c = x - 1;     end
      8:  begin r = y - s - 1; c = x;         end
      9:  begin r = y - s - 1; c = x + s;     end
      10: begin r = y;         c = x;         end
      11: begin r = y;         c = x + s;     end
      12: begin r = y - 1;     c = x;         end
      13: begin r = y - 1;     c = x + s;     end
      14: begin r = y + s;     c = x;         end
      15: begin r = y + s;     c = x + s;     end
      default: begin r = 0; c = 0; end
    endcase
    return r * IW + c;
  endfunction

  function automatic bit rejected(int x, int y, int s);
    return (s == 0) || (x < s + 1) || (y < s + 1) || (x + s > IW - 1) || (y + s > IH - 1);
  endfunction

  function automatic int box(int r0, int r1, int cA, int cB);
    int acc = 0;
    for (int r = r0; r <= r1; r++)
      for (int c = cA; c <= cB; c++) acc += img[r][c];
    return acc;
  endfunction

  function automatic int dxy_model(int x, int y, int s);
    return box(y-s, y-1, x-s, x-1) + box(y+1, y+s, x+1, x+s)
         - box(y-s, y-1, x+1, x+s) - box(y+1, y+s, x-s, x-1);
  endfunction

  function automatic int dxy_dut(int sel);
    int v [16];
    for (int i = 0; i < 16; i++) v[i] = int'(o_c(sel, i));
    return (v[0] + v[5] - v[1] - v[4]) + (v[10] + v[15] - v[11] - v[14])
         - (v[8] + v[13] - v[9] - v[12]) - (v[2] + v[7] - v[3] - v[6]);
  endfunction

  task automatic build_ii();
    int ii [IH][IW];
    for (int r = 0; r < IH; r++)
      for (int c = 0; c < IW; c++) begin
        ii[r][c] = img[r][c] + ((r > 0) ? ii[r-1][c] : 0) + ((c > 0) ? ii[r][c-1] : 0)
                 - ((r > 0 && c > 0) ? ii[r-1][c-1] : 0);
        mem[r*IW + c] = DW'(ii[r][c]);
      end
  endtask

  // One request on the selected build, checked cycle by cycle from acceptance.
  task automatic txn(input int sel, input int x, input int y, input int s, input bit hold);
    int lat, last, p;
    bit bad;
    int ea [16];
    logic [DW-1:0] ev [16];
    lat = (sel == 3) ? 3 : 1;
    p   = (sel == 3) ? 1 : 0;
    bad = rejected(x, y, s);
    for (int k = 0; k < 16; k++) begin
      ea[k] = bad ? 0 : corner_addr(k, x, y, s);
      ev[k] = bad ? '0 : mem[ea[k]];
    end
    @(negedge clk);
    rx = x[CW-1:0]; ry = y[CW-1:0]; rs = s[SW-1:0];
    set_rv(sel, 1'b1);
    chk("ready_idle", 64'(o_rdy(sel)), 64'd1);
    @(posedge clk); #1;
    if (!hold) set_rv(sel, 1'b0);
    if (bad) begin
      chk("rej_err", 64'(o_err(sel)), 64'd1);
      chk("rej_rden", 64'(o_en(sel)), 64'd0);
      chk("rej_ready", 64'(o_rdy(sel)), 64'd1);
      @(posedge clk); #1;
      chk("rej_err_pulse", 64'(o_err(sel)), 64'd0);
      chk("rej_rden2", 64'(o_en(sel)), 64'd0);
    end else begin
      last = hold ? 17 + lat : 18 + lat;
      for (int m = 1; m <= last; m++) begin
        if (m > 1) begin @(posedge clk); #1; end
        chk("rd_en", 64'(o_en(sel)), 64'(m <= 16));
        if (m <= 16) chk("rd_addr", 64'(o_addr(sel)), 64'(ea[m-1]));
        chk("dout_valid", 64'(o_dv(sel)), 64'(m == 17 + lat));
        if (m == 1) begin
          chk("busy_ready", 64'(o_rdy(sel)), 64'd0);
          chk("ok_err", 64'(o_err(sel)), 64'd0);
          for (int i = 0; i < 16; i++) chk("corner_hold", 64'(o_c(sel, i)), 64'(prev[p][i]));
        end
        if (m == 17 + lat) begin
          chk("done_ready", 64'(o_rdy(sel)), 64'd1);
          for (int i = 0; i < 16; i++) begin
            chk("corner", 64'(o_c(sel, i)), 64'(ev[i]));
            prev[p][i] = ev[i];
          end
        end
      end
    end
  endtask

  initial begin
    int x, y, s, sel;
    rst_n = 1'b0; rv1 = 1'b0; rv3 = 1'b0; rx = '0; ry = '0; rs = '0;
    for (int a = 0; a < IW*IH; a++) mem[a] = DW'(a);
    for (int i = 0; i < 16; i++) begin prev[0][i] = '0; prev[1][i] = '0; end
    repeat (3) @(posedge clk);
    #1;
    for (int q = 1; q <= 3; q += 2) begin
      chk("rst_ready", 64'(o_rdy(q)), 64'd1);
      chk("rst_rden", 64'(o_en(q)), 64'd0);
      chk("rst_addr", 64'(o_addr(q)), 64'd0);
      chk("rst_dv", 64'(o_dv(q)), 64'd0);
      chk("rst_err", 64'(o_err(q)), 64'd0);
      chk("rst_A", 64'(o_c(q, 0)), 64'd0);
    end
    @(negedge clk); rst_n = 1'b1;

    // RAM[a]=a: known corner values for both latencies.
    txn(1, 10, 10, 3, 1'b0);
    chk("s1_A", 64'(c1[0]), 64'd390);
    chk("s1_F", 64'(c1[5]), 64'd585);
    chk("s1_P", 64'(c1[15]), 64'd845);
    txn(3, 10, 10, 3, 1'b0);
    chk("s6_A", 64'(c3[0]), 64'd390);
    chk("s6_C", 64'(c3[2]), 64'd646);
    chk("s6_P", 64'(c3[15]), 64'd845);

    // Reset during issue aborts the fetch and clears the corners.
    @(negedge clk); rx = 10'd12; ry = 10'd12; rs = 6'd4; rv1 = 1'b1;
    @(posedge clk); #1; rv1 = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_rden", 64'(re1), 64'd0);
    for (int i = 0; i < 16; i++) begin
      chk("mid_rst_c1", 64'(c1[i]), 64'd0);
      chk("mid_rst_c3", 64'(c3[i]), 64'd0);
      prev[0][i] = '0; prev[1][i] = '0;
    end
    @(negedge clk); rst_n = 1'b1;
    for (int n = 0; n < 25; n++) begin
      @(posedge clk); #1;
      chk("aborted_dv", 64'(dv1), 64'd0);
      chk("aborted_rden", 64'(re1), 64'd0);
    end
    txn(1, 12, 12, 4, 1'b0);

    // Out-of-bounds requests on both builds.
    txn(1, 3, 10, 3, 1'b0);
    txn(1, 20, 61, 3, 1'b0);
    txn(1, 20, 20, 0, 1'b0);
    txn(3, 60, 20, 4, 1'b0);

    // req_valid held high: back-to-back acceptance every 18 cycles.
    for (int n = 0; n < 3; n++) begin
      s = $urandom_range(1, 12);
      txn(1, $urandom_range(s + 1, IW - 1 - s), $urandom_range(s + 1, IH - 1 - s), s, 1'b1);
    end
    txn(1, 30, 30, 7, 1'b0);

    // Dxy over a flat image is zero; lobes TL and BR set give 2*s*s.
    for (int r = 0; r < IH; r++) for (int c = 0; c < IW; c++) img[r][c] = 1;
    build_ii();
    txn(1, 20, 20, 5, 1'b0);
    chk("dxy_flat", 64'(dxy_dut(1)), 64'd0);
    for (int r = 0; r < IH; r++)
      for (int c = 0; c < IW; c++)
        img[r][c] = ((r >= 15 && r <= 19 && c >= 15 && c <= 19) ||
                     (r >= 21 && r <= 25 && c >= 21 && c <= 25)) ? 1 : 0;
    build_ii();
    txn(3, 20, 20, 5, 1'b0);
    chk("dxy_lobes", 64'(dxy_dut(3)), 64'd50);

    // Random image and random requests, either build, some out of bounds.
    for (int r = 0; r < IH; r++) for (int c = 0; c < IW; c++) img[r][c] = $urandom_range(0, 15);
    build_ii();
    for (int n = 0; n < 10; n++) begin
      sel = ($urandom_range(0, 1) == 0) ? 1 : 3;
      if ($urandom_range(0, 3) == 0) begin
        x = $urandom_range(0, 63); y = $urandom_range(0, 63); s = $urandom_range(0, 40);
      end else begin
        s = $urandom_range(1, 20);
        x = $urandom_range(s + 1, IW - 1 - s); y = $urandom_range(s + 1, IH - 1 - s);
      end
      txn(sel, x, y, s, 1'b0);
      if (!rejected(x, y, s)) chk("dxy_rand", 64'(dxy_dut(sel)), 64'(dxy_model(x, y, s)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/dxy_corner_fetch.md
Name: dxy_corner_fetch

Overview:
- Producer that feeds the Dxy box-filter pipeline. It accepts a Hessian sample request (centre x, y, lobe size s) and computes the 16 integral-image corner addresses of the four Dxy lobes.
- It reads those corners sequentially from the integral-image RAM. It then presents all 16 values at once as A..P with a single-cycle dout_valid pulse, which drives the Dxy stage's din_valid directly.
- The downstream stage has no backpressure, so this block paces itself: one request in flight at a time.

Parameters:
- DATA_WIDTH, 28, integral-image word width (matches the Dxy stage).
- ADDR_W, 16, RAM address width.
- COORD_W, 10, width of the x/y coordinates.
- S_W, 6, width of the lobe size.
- IMG_W, 64, image width in pixels (row stride).
- IMG_H, 64, image height in pixels.
- RD_LAT, 1, RAM read latency in cycles (1..3).

Ports:
- clk, input, 1, clock.
- rst_n, input, 1, reset, synchronous, active-low.
- req_valid, input, 1, request strobe.
- req_ready, output, 1, high when a request can be accepted.
- req_x, input, COORD_W, centre column.
- req_y, input, COORD_W, centre row.
- req_s, input, S_W, lobe side length in pixels.
- rd_en, output, 1, RAM read enable.
- rd_addr, output, ADDR_W, RAM address = row*IMG_W + col.
- rd_data, input, DATA_WIDTH, RAM read data, valid RD_LAT cycles after rd_en.
- A..P, output, DATA_WIDTH each, 16 registered corner values.
- dout_valid, output, 1, one-cycle pulse when A..P are valid.
- err, output, 1, one-cycle pulse when a request is rejected.

Behaviour:
- Reset (rst_n=0 at a clk edge): state IDLE; req_ready=1 after reset releases; rd_en=0; rd_addr=0; A..P=0; dout_valid=0; err=0; issue and capture counters=0. Reset mid-operation aborts the fetch; no dout_valid is produced for the aborted request.
- States: IDLE, ISSUE, DRAIN.
- req_ready = (state==IDLE). A request is accepted at edge T0 when req_valid && req_ready.
- Bounds check at accept. Reject if s==0, x<s+1, y<s+1, x+s>IMG_W-1 or y+s>IMG_H-1. On reject: err=1 at T0+1, no reads, state stays IDLE.
- Corner coordinates as (row, col), grouped by lobe:
  - Top-left lobe: A=(y-s-1, x-s-1), B=(y-s-1, x-1), E=(y-1, x-s-1), F=(y-1, x-1).
  - Bottom-right lobe: K=(y, x), L=(y, x+s), O=(y+s, x), P=(y+s, x+s).
  - Top-right lobe: I=(y-s-1, x), J=(y-s-1, x+s), M=(y-1, x), N=(y-1, x+s).
  - Bottom-left lobe: C=(y, x-s-1), D=(y, x-1), G=(y+s, x-s-1), H=(y+s, x-1).
  - With this mapping, each lobe sum is TL+BR-TR-BL in the Dxy datapath.
- ISSUE phase: rd_en=1 for exactly 16 consecutive cycles, T0+1..T0+16. Addresses go out in order A,B,C,...,P, with index k at T0+1+k. Row bases are precomputed at accept; no per-cycle multiply is required.
- Capture: rd_data for index k is captured at edge T0+1+k+RD_LAT into that index's output register. Output registers change only during capture.
- DRAIN phase: entered after the 16th issue and held until the last capture, at T0+16+RD_LAT.
- Completion: dout_valid=1 for one cycle at T0+17+RD_LAT. In that same cycle state=IDLE and req_ready=1.
- Occupancy: one request every 17+RD_LAT cycles at minimum.
- A..P hold their values after dout_valid until the next capture overwrites them.
- req_valid while busy: ignored (not queued); the requester must hold it until accepted.
- Address arithmetic is unsigned. The bounds check guarantees no negative or wrapped coordinate ever reaches rd_addr.

Test Plan:
1. RAM[a]=a, IMG_W=64, RD_LAT=1, request x=10, y=10, s=3 -> rd_addr sequence starts 390, 393, 646 (C=(10,6)); A=390, F=585, P=845; dout_valid at T0+18, exactly one pulse.
2. Integral image of an all-ones image, II(r,c)=(r+1)(c+1), fed to a Dxy model with x=20, y=20, s=5 -> (A+F-B-E)+(K+P-L-O)-(I+N-J-M)-(C+H-D-G)=0; a checkerboard-of-lobes image gives the expected nonzero value.
3. Out-of-bounds cases: x=3, s=3; then y+s=64; then s=0 -> err pulses at T0+1 each time; rd_en never asserts; req_ready stays 1.
4. req_valid held high continuously -> back-to-back requests spaced exactly 18 cycles (RD_LAT=1); earlier A..P stable until overwritten.
5. rst_n=0 at T0+8 mid-issue -> next cycle rd_en=0, A..P=0; no dout_valid; a fresh request afterwards completes normally.
6. RD_LAT=3 build, same stimulus as scenario 1 -> identical A..P values; dout_valid at T0+20.
